control_decoder: RTL and testbench
==================================

Name: control_decoder

Overview:
- Main instruction decoder of the 8-bit CPU.
- Maps the current instruction byte, the two-phase execution flag `cycle` and the ALU carry flag to every datapath and sequencing strobe: memory access, jumps, register-file selects/writes, ALU opcode, I/O strobes and one-hot signal lines.
- Sits between the instruction register and the datapath.
- Purely combinational from `inst`/`cycle`/`carry`. Clock and reset exist only for interface uniformity.

Parameters:
- None.

Ports:
- clk    input   1  system clock; no decode logic depends on it
- rst    input   1  synchronous active-high reset; no decode logic depends on it
- inst   input   8  current instruction byte, i7..i0
- cycle  input   1  execution phase: 0 = first cycle, 1 = second cycle
- carry  input   1  ALU carry flag
- M      output  1  memory-operation phase
- S      output  1  S bit
- J      output  1  take jump
- LJ     output  1  long-jump/link class
- CLI    output  1  clear interrupt
- LJR    output  1  long-jump return
- MW     output  1  memory write
- MC     output  1  memory cycle, first phase
- RD     output  1  I/O read strobe
- WR     output  1  I/O write strobe
- Y      output  1  operand select
- RS     output  2  register select
- WA     output  1  write accumulator
- ISP    output  1  stack-pointer instruction
- WC     output  1  write carry
- ALU    output  4  ALU function code
- SIG    output  8  one-hot signal lines

Behaviour:
- Zero latency: all outputs are combinational functions of `inst`, `cycle` and `carry`.
- `clk` and `rst` do not affect any output; there are no registers.
- Outputs are fully defined for all 1024 input combinations; no X is allowed.
- Shorthand: Z = ~i7 & ~i6 & ~i5 (group-0 prefix); A = (i6 & ~i7) | (cycle & i6 & i5).
- M = i7 & ~i6 & cycle
- S = i4
- J = i7 & i6 & i5 & cycle & ~(carry & i4); i4 makes the jump conditional on carry clear.
- LJ = Z & i4 & ~i3
- CLI = LJ & i1
- LJR = LJ & i2
- MW = M & i5
- MC = i7 & ~cycle
- RD = Z & ~i4 & i2
- WR = Z & ~i4 & i3
- Y = i5
- RS = inst[1:0]
- ALU = inst[3:0]
- ISP = ~i7 & ~i6 & i5
- WA = (M & ~i5) | (A & ~(i4 & ~i3))
- WC = (A | ISP) & i4
- SIG = (8'b1 << inst[2:0]) when Z & i4 & i3, else 8'h00.
- SIG is never multi-hot.

Test Plan:
- Long-jump decode:
  - inst=0x10, cycle=0, carry=0 -> LJ=1, S=1, CLI=0, LJR=0, ALU=0, RS=0, WA=0, WC=0, SIG=0, MC=0.
  - inst=0x16 -> LJ=1, CLI=1, LJR=1, RS=2, ALU=6.
- Conditional jump:
  - inst=0xF0, cycle=1, carry=1 -> J=0, WA=0, WC=1, M=0.
  - Same with carry=0 -> J=1.
  - inst=0xE0, cycle=1, carry=1 -> J=1.
  - Any cycle=0 -> J=0.
- Memory phases:
  - inst=0x80, cycle=1 -> M=1, MW=0, WA=1, MC=0.
  - inst=0x80, cycle=0 -> M=0, MC=1, WA=0.
  - inst=0xA0, cycle=1 -> M=1, MW=1, Y=1, WA=0.
- I/O and signals:
  - inst=0x0C -> RD=1, WR=1, SIG=0.
  - inst=0x1D -> SIG=0x20, LJ=0, ALU=0xD, RS=1, S=1.
- Stack/write flags:
  - inst=0x20 -> ISP=1, WC=0.
  - inst=0x30 -> ISP=1, WC=1, WA=0.
  - inst=0x50, cycle=0 -> WA=0, WC=1.
  - inst=0x58 -> WA=1, WC=1.
- Exhaustive sweep of all 1024 {inst, cycle, carry} combinations:
  - Every output matches the equations above.
  - Toggling `clk`/`rst` mid-sweep changes nothing.

Source files
------------

// File: rtl/control_decoder.sv
// Main instruction decoder of the 8-bit CPU: turns the instruction byte, execution
// phase and carry flag into every datapath and sequencing strobe, with zero latency.
module control_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] inst,
    input  logic       cycle,
    input  logic       carry,
    output logic       M,
    output logic       S,
    output logic       J,
    output logic       LJ,
    output logic       CLI,
    output logic       LJR,
    output logic       MW,
    output logic       MC,
    output logic       RD,
    output logic       WR,
    output logic       Y,
    output logic [1:0] RS,
    output logic       WA,
    output logic       ISP,
    output logic       WC,
    output logic [3:0] ALU,
    output logic [7:0] SIG
);

    logic grp0;
    logic alu_class;

    // Clock and reset are kept only so every block shares the same port shape.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    // grp0: top three opcode bits clear; alu_class: instructions that write back through the ALU.
    assign grp0      = ~inst[7] & ~inst[6] & ~inst[5];
    assign alu_class = (inst[6] & ~inst[7]) | (cycle & inst[6] & inst[5]);

    assign M   = inst[7] & ~inst[6] & cycle;
    assign S   = inst[4];
    assign J   = inst[7] & inst[6] & inst[5] & cycle & ~(carry & inst[4]);
    assign LJ  = grp0 & inst[4] & ~inst[3];
    assign CLI = LJ & inst[1];
    assign LJR = LJ & inst[2];
    assign MW  = M & inst[5];
    assign MC  = inst[7] & ~cycle;
    assign RD  = grp0 & ~inst[4] & inst[2];
    assign WR  = grp0 & ~inst[4] & inst[3];
    assign Y   = inst[5];
    assign RS  = inst[1:0];
    assign ALU = inst[3:0];
    assign ISP = ~inst[7] & ~inst[6] & inst[5];
    assign WA  = (M & ~inst[5]) | (alu_class & ~(inst[4] & ~inst[3]));
    assign WC  = (alu_class | ISP) & inst[4];

    always_comb begin
        SIG = 8'h00;
        if (grp0 && inst[4] && inst[3]) begin
            SIG = 8'h01 << inst[2:0];
        end
    end

endmodule

// File: tb/tb_control_decoder.sv
// Bench for control_decoder: directed test-plan vectors plus a full sweep of
// {inst, cycle, carry}, every cycle compared against a group-based behavioural model.
module tb_control_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] inst = 8'h00;
    logic       cycle = 1'b0;
    logic       carry = 1'b0;

    logic       M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, WA, ISP, WC;
    logic [1:0] RS;
    logic [3:0] ALU;
    logic [7:0] SIG;

    control_decoder dut (
        .clk(clk), .rst(rst), .inst(inst), .cycle(cycle), .carry(carry),
        .M(M), .S(S), .J(J), .LJ(LJ), .CLI(CLI), .LJR(LJR), .MW(MW), .MC(MC),
        .RD(RD), .WR(WR), .Y(Y), .RS(RS), .WA(WA), .ISP(ISP), .WC(WC),
        .ALU(ALU), .SIG(SIG)
    );

    always #5 clk = ~clk;

    // Output vector layout: {M,S,J,LJ,CLI,LJR,MW,MC,RD,WR,Y,RS,WA,ISP,WC,ALU,SIG}
    logic [27:0] dut_vec;
    assign dut_vec = {M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, RS, WA, ISP, WC, ALU, SIG};

    typedef enum int {F_M, F_S, F_J, F_LJ, F_CLI, F_LJR, F_MW, F_MC, F_RD, F_WR,
                      F_Y, F_RS, F_WA, F_ISP, F_WC, F_ALU, F_SIG} field_e;

    function automatic string field_name(input int fid);
        case (fid)
            F_M:   return "M";
            F_S:   return "S";
            F_J:   return "J";
            F_LJ:  return "LJ";
            F_CLI: return "CLI";
            F_LJR: return "LJR";
            F_MW:  return "MW";
            F_MC:  return "MC";
            F_RD:  return "RD";
            F_WR:  return "WR";
            F_Y:   return "Y";
            F_RS:  return "RS";
            F_WA:  return "WA";
            F_ISP: return "ISP";
            F_WC:  return "WC";
            F_ALU: return "ALU";
            default: return "SIG";
        endcase
    endfunction

    function automatic logic [7:0] get_field(input logic [27:0] v, input int fid);
        case (fid)
            F_M:   return {7'd0, v[27]};
            F_S:   return {7'd0, v[26]};
            F_J:   return {7'd0, v[25]};
            F_LJ:  return {7'd0, v[24]};
            F_CLI: return {7'd0, v[23]};
            F_LJR: return {7'd0, v[22]};
            F_MW:  return {7'd0, v[21]};
            F_MC:  return {7'd0, v[20]};
            F_RD:  return {7'd0, v[19]};
            F_WR:  return {7'd0, v[18]};
            F_Y:   return {7'd0, v[17]};
            F_RS:  return {6'd0, v[16:15]};
            F_WA:  return {7'd0, v[14]};
            F_ISP: return {7'd0, v[13]};
            F_WC:  return {7'd0, v[12]};
            F_ALU: return {4'd0, v[11:8]};
            default: return v[7:0];
        endcase
    endfunction

    // Model reasons about the opcode group (top three bits) instead of individual bits.
    function automatic logic [27:0] model(input logic [7:0] in, input logic cyc, input logic car);
        int  grp;
        bit  mem_op, jmp, lj, cli, ljr, mw, mc, rd, wr, isp, alu_grp, wa, wc;
        int  sig;
        grp     = int'(in[7:5]);
        mem_op  = (grp == 4 || grp == 5) && cyc;
        jmp     = (grp == 7) && cyc && !(in[4] && car);
        lj      = (grp == 0) && in[4] && !in[3];
        cli     = lj && in[1];
        ljr     = lj && in[2];
        mw      = mem_op && grp == 5;
        mc      = grp >= 4 && !cyc;
        rd      = (grp == 0) && !in[4] && in[2];
        wr      = (grp == 0) && !in[4] && in[3];
        isp     = (grp == 1);
        alu_grp = (grp == 2 || grp == 3) || (cyc && (grp == 3 || grp == 7));
        wa      = (mem_op && grp == 4) || (alu_grp && !(in[4] && !in[3]));
        wc      = (alu_grp || isp) && in[4];
        sig     = ((grp == 0) && in[4] && in[3]) ? (2 ** int'(in[2:0])) : 0;
        return {mem_op, in[4], jmp, lj, cli, ljr, mw, mc, rd, wr, in[5], in[1:0],
                wa, isp, wc, in[3:0], 8'(sig)};
    endfunction

    int          checks = 0;
    int          failures = 0;
    logic        check_en = 1'b0;
    logic        lit_valid = 1'b0;
    int          lit_fid = 0;
    logic [7:0]  lit_val = 8'h00;
    logic [27:0] exp_v, act_v;

    // Single compare process: model every cycle, plus the directed literal when present.
    always @(posedge clk) begin
        #1;
        if (check_en) begin
            exp_v = model(inst, cycle, carry);
            act_v = dut_vec;
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL model inst=%02h cycle=%0b carry=%0b rst=%0b got=%07h expected=%07h",
                         inst, cycle, carry, rst, act_v, exp_v);
            end
            if (lit_valid) begin
                checks++;
                if (get_field(act_v, lit_fid) !== lit_val) begin
                    failures++;
                    $display("FAIL directed %s inst=%02h cycle=%0b carry=%0b got=%02h expected=%02h",
                             field_name(lit_fid), inst, cycle, carry, get_field(act_v, lit_fid), lit_val);
                end
                checks++;
                if (get_field(exp_v, lit_fid) !== lit_val) begin
                    failures++;
                    $display("FAIL model_pin %s inst=%02h cycle=%0b carry=%0b got=%02h expected=%02h",
                             field_name(lit_fid), inst, cycle, carry, get_field(exp_v, lit_fid), lit_val);
                end
            end
        end
    end

    typedef struct {
        logic [7:0] in;
        logic       cyc;
        logic       car;
        int         fid;
        logic [7:0] val;
    } lit_t;

    lit_t lits[$];

    task automatic add(input logic [7:0] in, input logic cyc, input logic car,
                       input int fid, input logic [7:0] val);
        lit_t e;
        e.in = in; e.cyc = cyc; e.car = car; e.fid = fid; e.val = val;
        lits.push_back(e);
    endtask

    task automatic apply(input logic [7:0] in, input logic cyc, input logic car);
        @(negedge clk);
        inst  = in;
        cycle = cyc;
        carry = car;
    endtask

    initial begin
        // Reset state: all-zero inputs give all-zero outputs, with rst asserted.
        add(8'h00, 1'b0, 1'b0, F_SIG, 8'h00);
        add(8'h00, 1'b0, 1'b0, F_ISP, 8'h00);
        // Long jump
        add(8'h10, 1'b0, 1'b0, F_LJ, 8'h01);
        add(8'h10, 1'b0, 1'b0, F_S, 8'h01);
        add(8'h10, 1'b0, 1'b0, F_CLI, 8'h00);
        add(8'h10, 1'b0, 1'b0, F_LJR, 8'h00);
        add(8'h10, 1'b0, 1'b0, F_ALU, 8'h00);
        add(8'h10, 1'b0, 1'b0, F_RS, 8'h00);
        add(8'h10, 1'b0, 1'b0, F_WA, 8'h00);
        add(8'h10, 1'b0, 1'b0, F_WC, 8'h00);
        add(8'h10, 1'b0, 1'b0, F_SIG, 8'h00);
        add(8'h10, 1'b0, 1'b0, F_MC, 8'h00);
        add(8'h16, 1'b0, 1'b0, F_LJ, 8'h01);
        add(8'h16, 1'b0, 1'b0, F_CLI, 8'h01);
        add(8'h16, 1'b0, 1'b0, F_LJR, 8'h01);
        add(8'h16, 1'b0, 1'b0, F_RS, 8'h02);
        add(8'h16, 1'b0, 1'b0, F_ALU, 8'h06);
        // Conditional jump
        add(8'hF0, 1'b1, 1'b1, F_J, 8'h00);
        add(8'hF0, 1'b1, 1'b1, F_WA, 8'h00);
        add(8'hF0, 1'b1, 1'b1, F_WC, 8'h01);
        add(8'hF0, 1'b1, 1'b1, F_M, 8'h00);
        add(8'hF0, 1'b1, 1'b0, F_J, 8'h01);
        add(8'hE0, 1'b1, 1'b1, F_J, 8'h01);
        add(8'hE0, 1'b0, 1'b1, F_J, 8'h00);
        add(8'hF0, 1'b0, 1'b0, F_J, 8'h00);
        // Memory phases
        add(8'h80, 1'b1, 1'b0, F_M, 8'h01);
        add(8'h80, 1'b1, 1'b0, F_MW, 8'h00);
        add(8'h80, 1'b1, 1'b0, F_WA, 8'h01);
        add(8'h80, 1'b1, 1'b0, F_MC, 8'h00);
        add(8'h80, 1'b0, 1'b0, F_M, 8'h00);
        add(8'h80, 1'b0, 1'b0, F_MC, 8'h01);
        add(8'h80, 1'b0, 1'b0, F_WA, 8'h00);
        add(8'hA0, 1'b1, 1'b0, F_M, 8'h01);
        add(8'hA0, 1'b1, 1'b0, F_MW, 8'h01);
        add(8'hA0, 1'b1, 1'b0, F_Y, 8'h01);
        add(8'hA0, 1'b1, 1'b0, F_WA, 8'h00);
        // I/O and signal lines
        add(8'h0C, 1'b0, 1'b0, F_RD, 8'h01);
        add(8'h0C, 1'b0, 1'b0, F_WR, 8'h01);
        add(8'h0C, 1'b0, 1'b0, F_SIG, 8'h00);
        add(8'h1D, 1'b0, 1'b0, F_SIG, 8'h20);
        add(8'h1D, 1'b0, 1'b0, F_LJ, 8'h00);
        add(8'h1D, 1'b0, 1'b0, F_ALU, 8'h0D);
        add(8'h1D, 1'b0, 1'b0, F_RS, 8'h01);
        add(8'h1D, 1'b0, 1'b0, F_S, 8'h01);
        // Stack and write flags
        add(8'h20, 1'b0, 1'b0, F_ISP, 8'h01);
        add(8'h20, 1'b0, 1'b0, F_WC, 8'h00);
        add(8'h30, 1'b0, 1'b0, F_ISP, 8'h01);
        add(8'h30, 1'b0, 1'b0, F_WC, 8'h01);
        add(8'h30, 1'b0, 1'b0, F_WA, 8'h00);
        add(8'h50, 1'b0, 1'b0, F_WA, 8'h00);
        add(8'h50, 1'b0, 1'b0, F_WC, 8'h01);
        add(8'h58, 1'b0, 1'b0, F_WA, 8'h01);
        add(8'h58, 1'b0, 1'b0, F_WC, 8'h01);

        check_en = 1'b1;
        for (int k = 0; k < lits.size(); k++) begin
            apply(lits[k].in, lits[k].cyc, lits[k].car);
            lit_fid   = lits[k].fid;
            lit_val   = lits[k].val;
            lit_valid = 1'b1;
            if (k == 2) rst = 1'b0;
            $display("directed %0d: inst=%02h cycle=%0b carry=%0b %s expect %02h",
                     k, lits[k].in, lits[k].cyc, lits[k].car, field_name(lits[k].fid), lits[k].val);
        end
        @(negedge clk);
        lit_valid = 1'b0;

        // Full sweep; rst is pulsed mid-way and must not disturb any output.
        for (int i = 0; i < 1024; i++) begin
            apply(8'(i >> 2), 1'((i >> 1) & 1), 1'(i & 1));
            rst = (i >= 300 && i < 340) ? 1'b1 : 1'b0;
        end
        @(posedge clk);
        #3;
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
